dtree_node_memory: RTL and testbench



---
 rtl/dtree_pkg.sv | 56 +++++
 rtl/dtree_record_assembler.sv | 46 ++++
 rtl/dtree_node_memory.sv | 133 +++++++++++++
 tb/tb_dtree_node_memory.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared constants, record layout helpers and the load FSM state type for
// the decision-tree node memory.
package dtree_pkg;

    localparam int DEF_FEATURES      = 3;
    localparam int DEF_COEFF_WIDTH   = 4;
    localparam int DEF_BIAS_WIDTH    = 10;
    localparam int DEF_NODE_COUNT    = 5;
    localparam int DEF_CHANNEL_COUNT = 1;
    localparam int DEF_CFG_WIDTH     = 8;

    // Record bit count: flags + one-hot + coefficients + bias + spare.
    function automatic int node_size(input int f, input int cw, input int bw);
        return 2 + f + (f - 1) * cw + bw + 1;
    endfunction

    // Config words needed to carry one record.
    function automatic int words(input int ns, input int cfgw);
        return (ns + cfgw - 1) / cfgw;
    endfunction

    // Index width with a floor of one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Field positions inside a record (LSB offsets), MSB to LSB order:
    // flags, one-position one-hot, coeff0..coeff(F-2), bias, spare.
    localparam int FLAGS_W   = 2;
    localparam int BIAS_LSB  = 1;
    localparam int SPARE_LSB = 0;

    function automatic int flags_lsb(input int ns);
        return ns - FLAGS_W;
    endfunction

    function automatic int onepos_lsb(input int ns, input int f);
        return ns - FLAGS_W - f;
    endfunction

    function automatic int coeff_lsb(input int ns, input int f, input int cw, input int i);
        return ns - FLAGS_W - f - (i + 1) * cw;
    endfunction

    localparam int DEF_NODE_SIZE = node_size(DEF_FEATURES, DEF_COEFF_WIDTH, DEF_BIAS_WIDTH);
    localparam int DEF_WORDS     = words(DEF_NODE_SIZE, DEF_CFG_WIDTH);
    localparam int DEF_CHW       = idx_w(DEF_CHANNEL_COUNT);
    localparam int DEF_NIW       = idx_w(DEF_NODE_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/dtree_record_assembler.sv
// Collects config words MSB-first into a record and flags the word that
// completes it. The completed record is presented combinationally so the
// array write lands on the same edge as the final word.
module dtree_record_assembler
    import dtree_pkg::*;
#(
    parameter int CFG_WIDTH = DEF_CFG_WIDTH,
    parameter int WORDS     = DEF_WORDS,
    parameter int NODE_SIZE = DEF_NODE_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_accept,
    input  logic [CFG_WIDTH-1:0] i_word,
    output logic                 o_rec_valid,
    output logic [NODE_SIZE-1:0] o_record
);

    localparam int SW  = WORDS * CFG_WIDTH;
    localparam int WCW = idx_w(WORDS);

    logic [SW-1:0]  r_shift;
    logic [WCW-1:0] r_word_cnt;
    logic [SW-1:0]  w_shift_next;

    // Oldest word drifts toward the MSB; truncation drops words already shifted out.
    assign w_shift_next = SW'({r_shift, i_word});
    assign o_rec_valid  = i_accept && (r_word_cnt == WCW'(WORDS - 1));
    assign o_record     = w_shift_next[NODE_SIZE-1:0];

    // Shift register and word counter; cleared on reset and on a new load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_word_cnt <= '0;
        end else if (i_clear) begin
            r_shift    <= '0;
            r_word_cnt <= '0;
        end else if (i_accept) begin
            r_shift    <= w_shift_next;
            r_word_cnt <= o_rec_valid ? '0 : r_word_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dtree_node_memory.sv
// Node-record store: loads packed records from a narrow config stream into
// a register array and serves them by zero-latency lookup.
module dtree_node_memory
    import dtree_pkg::*;
#(
    parameter int FEATURES      = DEF_FEATURES,
    parameter int COEFF_WIDTH   = DEF_COEFF_WIDTH,
    parameter int BIAS_WIDTH    = DEF_BIAS_WIDTH,
    parameter int NODE_COUNT    = DEF_NODE_COUNT,
    parameter int CHANNEL_COUNT = DEF_CHANNEL_COUNT,
    parameter int CFG_WIDTH     = DEF_CFG_WIDTH,
    localparam int NODE_SIZE    = node_size(FEATURES, COEFF_WIDTH, BIAS_WIDTH),
    localparam int WORDS        = words(NODE_SIZE, CFG_WIDTH),
    localparam int CHW          = idx_w(CHANNEL_COUNT),
    localparam int NIW          = idx_w(NODE_COUNT),
    localparam int LCW          = $clog2(NODE_COUNT * CHANNEL_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    input  logic [CFG_WIDTH-1:0] cfg_data,
    output logic                 cfg_ready,
    output logic                 cfg_error,
    input  logic [CHW-1:0]       ch_index,
    input  logic [NIW-1:0]       node_index,
    input  logic                 read_mem,
    output logic [NODE_SIZE-1:0] node_data,
    output logic                 mem_ready,
    output logic [LCW-1:0]       load_count
);

    state_t               r_state;
    state_t               w_state_next;
    logic [NIW-1:0]       r_node_cnt;
    logic [CHW-1:0]       r_ch_cnt;
    logic [LCW-1:0]       r_load_cnt;
    logic                 r_cfg_error;
    logic [NODE_SIZE-1:0] r_mem [CHANNEL_COUNT][NODE_COUNT];

    logic                 w_accept;
    logic                 w_rec_valid;
    logic [NODE_SIZE-1:0] w_record;
    logic                 w_last_node;
    logic                 w_last_rec;

    // A start pulse always wins over a coincident word.
    assign w_accept    = cfg_valid && cfg_ready && !cfg_start;
    assign w_last_node = (r_node_cnt == NIW'(NODE_COUNT - 1));
    assign w_last_rec  = w_rec_valid && w_last_node && (r_ch_cnt == CHW'(CHANNEL_COUNT - 1));

    dtree_record_assembler #(
        .CFG_WIDTH (CFG_WIDTH),
        .WORDS     (WORDS),
        .NODE_SIZE (NODE_SIZE)
    ) u_asm (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (cfg_start),
        .i_accept    (w_accept),
        .i_word      (cfg_data),
        .o_rec_valid (w_rec_valid),
        .o_record    (w_record)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        w_state_next = r_state;
        cfg_ready    = 1'b0;
        mem_ready    = 1'b0;
        case (r_state)
            LOAD:    cfg_ready = 1'b1;
            READY:   mem_ready = 1'b1;
            default: ;
        endcase
        if (cfg_start)                         w_state_next = LOAD;
        else if (r_state == LOAD && w_last_rec) w_state_next = READY;
    end

    // Record placement counters and the sticky out-of-load word error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_node_cnt  <= '0;
            r_ch_cnt    <= '0;
            r_load_cnt  <= '0;
            r_cfg_error <= 1'b0;
        end else if (cfg_start) begin
            r_node_cnt  <= '0;
            r_ch_cnt    <= '0;
            r_load_cnt  <= '0;
            r_cfg_error <= 1'b0;
        end else begin
            if (w_rec_valid) begin
                r_load_cnt <= r_load_cnt + 1'b1;
                if (w_last_node) begin
                    r_node_cnt <= '0;
                    r_ch_cnt   <= w_last_rec ? '0 : r_ch_cnt + 1'b1;
                end else begin
                    r_node_cnt <= r_node_cnt + 1'b1;
                end
            end
            if (cfg_valid && r_state != LOAD) r_cfg_error <= 1'b1;
        end
    end

    // Record array; reset clears it so a partial image never survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNEL_COUNT; c++)
                for (int n = 0; n < NODE_COUNT; n++)
                    r_mem[c][n] <= '0;
        end else if (w_rec_valid) begin
            r_mem[r_ch_cnt][r_node_cnt] <= w_record;
        end
    end

    // Zero-latency lookup; disabled or out-of-range reads return zero.
    always_comb begin
        node_data = '0;
        if (read_mem && (32'(ch_index) < CHANNEL_COUNT) && (32'(node_index) < NODE_COUNT))
            node_data = r_mem[ch_index][node_index];
    end

    assign cfg_error  = r_cfg_error;
    assign load_count = r_load_cnt;

endmodule

// File: tb/tb_dtree_node_memory.sv
// Directed bench for dtree_node_memory: single-channel default instance
// plus a two-channel instance sharing the config stream.
module tb_dtree_node_memory;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_start;
    logic       cfg_valid;
    logic       sel;
    logic [7:0] cfg_data;

    logic        cfg_valid_a, cfg_ready_a, cfg_error_a, mem_ready_a, read_a;
    logic [0:0]  ch_a;
    logic [2:0]  node_a;
    logic [23:0] node_data_a;
    logic [2:0]  load_count_a;

    logic        cfg_valid_b, cfg_ready_b, cfg_error_b, mem_ready_b, read_b;
    logic [0:0]  ch_b;
    logic [2:0]  node_b;
    logic [23:0] node_data_b;
    logic [3:0]  load_count_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign cfg_valid_a = cfg_valid & ~sel;
    assign cfg_valid_b = cfg_valid & sel;

    dtree_node_memory dut_a (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid_a),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready_a), .cfg_error(cfg_error_a),
        .ch_index(ch_a), .node_index(node_a), .read_mem(read_a),
        .node_data(node_data_a), .mem_ready(mem_ready_a), .load_count(load_count_a)
    );

    dtree_node_memory #(.CHANNEL_COUNT(2)) dut_b (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid_b),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready_b), .cfg_error(cfg_error_b),
        .ch_index(ch_b), .node_index(node_b), .read_mem(read_b),
        .node_data(node_data_b), .mem_ready(mem_ready_b), .load_count(load_count_b)
    );

    // Pattern A: record k = {00, k, A0+k}.
    function automatic logic [23:0] rec_a(input int k);
        return {8'h00, 8'(k), 8'(8'hA0 + k)};
    endfunction

    // Pattern B: record k = {40, 10+k, 50+k}.
    function automatic logic [23:0] rec_b(input int k);
        return {8'h40, 8'(8'h10 + k), 8'(8'h50 + k)};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        cfg_data  = d;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic load(input bit b, input bit pat_b, input int nrec, input bit gap);
        logic [23:0] r;
        sel = b;
        for (int i = 0; i < nrec; i++) begin
            r = pat_b ? rec_b(i) : rec_a(i);
            for (int w = 0; w < 3; w++) begin
                if (gap && !(i == 0 && w == 0)) begin
                    @(posedge clk);
                    #1;
                end
                if (i == nrec - 1 && w == 2)
                    check("rdy_before_last", 32'(b ? mem_ready_b : mem_ready_a), 0);
                send(r[23 - 8 * w -: 8]);
            end
        end
        check("rdy_after_last", 32'(b ? mem_ready_b : mem_ready_a), 1);
    endtask

    task automatic rd_a(input int n, input logic [23:0] exp, input string tag);
        @(negedge clk);
        node_a = 3'(n);
        read_a = 1'b1;
        #1;
        check(tag, 32'(node_data_a), 32'(exp));
    endtask

    task automatic rd_b(input int c, input int n, input logic [23:0] exp, input string tag);
        @(negedge clk);
        ch_b   = 1'(c);
        node_b = 3'(n);
        read_b = 1'b1;
        #1;
        check(tag, 32'(node_data_b), 32'(exp));
    endtask

    task automatic chk_all_a(input bit pat_b, input bit zero, input string tag);
        for (int k = 0; k < 5; k++)
            rd_a(k, zero ? 24'h0 : (pat_b ? rec_b(k) : rec_a(k)), $sformatf("%s_n%0d", tag, k));
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; sel = 1'b0; cfg_data = 8'h00;
        ch_a = '0; node_a = '0; read_a = 1'b0;
        ch_b = '0; node_b = '0; read_b = 1'b0;
        #23;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset / idle state
        check("rst_mem_ready", 32'(mem_ready_a), 0);
        check("rst_cfg_ready", 32'(cfg_ready_a), 0);
        check("rst_cfg_error", 32'(cfg_error_a), 0);
        check("rst_load_count", 32'(load_count_a), 0);
        chk_all_a(0, 1, "rst_read");

        // Unbroken full load, pattern A
        start_pulse();
        check("load_cfg_ready", 32'(cfg_ready_a), 1);
        load(0, 0, 5, 0);
        check("full_load_count", 32'(load_count_a), 5);
        check("full_cfg_ready", 32'(cfg_ready_a), 0);
        rd_a(3, 24'h0003A3, "node3");
        check("node3_flags", 32'(node_data_a[23:22]), 0);
        check("node3_bias", 32'(node_data_a[10:1]), 32'h1D1);
        chk_all_a(0, 0, "full");
        @(negedge clk); read_a = 1'b0; #1;
        check("read_disabled", 32'(node_data_a), 0);
        rd_a(5, 24'h0, "node_oor");
        @(negedge clk); node_a = 3'd0; ch_a = 1'b1; #1;
        check("ch_oor", 32'(node_data_a), 0);
        ch_a = 1'b0;

        // Word offered in READY
        sel = 1'b0;
        send(8'h77);
        check("ready_err", 32'(cfg_error_a), 1);
        check("ready_still", 32'(mem_ready_a), 1);
        rd_a(0, rec_a(0), "ready_node0_kept");

        // Restart with coincident word, then gapped load of pattern B
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hFF;
        @(posedge clk);
        #1;
        cfg_start = 1'b0; cfg_valid = 1'b0;
        check("restart_err_clr", 32'(cfg_error_a), 0);
        check("restart_mem_ready", 32'(mem_ready_a), 0);
        check("restart_load_count", 32'(load_count_a), 0);
        check("restart_cfg_ready", 32'(cfg_ready_a), 1);
        load(0, 1, 5, 1);
        check("gap_load_count", 32'(load_count_a), 5);
        chk_all_a(1, 0, "gap");

        // Reset in the middle of a load
        start_pulse();
        sel = 1'b0;
        for (int i = 0; i < 7; i++) send(8'h5A);
        check("mid_load_count", 32'(load_count_a), 2);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_mem_ready", 32'(mem_ready_a), 0);
        check("midrst_cfg_ready", 32'(cfg_ready_a), 0);
        check("midrst_load_count", 32'(load_count_a), 0);
        chk_all_a(0, 1, "midrst");
        send(8'h33);
        check("idle_err", 32'(cfg_error_a), 1);
        check("idle_cfg_ready", 32'(cfg_ready_a), 0);
        start_pulse();
        check("reload_err_clr", 32'(cfg_error_a), 0);
        load(0, 0, 5, 0);
        chk_all_a(0, 0, "reload");

        // Two-channel instance
        start_pulse();
        load(1, 0, 10, 0);
        check("b_load_count", 32'(load_count_b), 10);
        check("b_cfg_error", 32'(cfg_error_b), 0);
        rd_b(1, 0, rec_a(5), "b_ch1_n0");
        rd_b(0, 4, rec_a(4), "b_ch0_n4");
        rd_b(1, 4, rec_a(9), "b_ch1_n4");
        rd_b(0, 0, rec_a(0), "b_ch0_n0");
        rd_b(1, 5, 24'h0, "b_node_oor");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
